// File: rtl/ext_bus_master.sv
// ---------------------------------------------------------------------------
// ext_bus_master
//
// Purpose:
//   Bus-master sequencer between the core load/store port and the pad ring.
//   It takes one request at a time and checks its size, alignment and range.
//   A legal request runs a one-cycle SETUP phase and then an ACCESS phase on
//   the external bus. ACCESS ends on bus_rdy or after TIMEOUT_CYCLES cycles.
//   The block then returns a single response strobe. Load data is lane
//   extracted and then sign- or zero-extended.
//
// Handshake:
//   The core raises i_req_valid and holds every request field stable until
//   it sees o_req_ready high. o_req_ready is high only in IDLE. The request
//   is taken on the rising edge where both are high. o_rsp_valid is a
//   one-cycle strobe with no back-pressure. o_rsp_err and o_rsp_rdata are
//   meaningful only while o_rsp_valid is high.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_*/o_req_ready   core request channel
//   o_rsp_*               core response channel
//   i_bus_rdy             external slave completion
//   i_data_bus_recv       read data from the pads
//   o_bus_*               external bus control, address and size
//   o_data_bus_drv        lane-replicated write data to the pads
//   o_data_bus_o_en/i_en  pad output/input enables
//   o_dbg_state           current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// ---------------------------------------------------------------------------
module ext_bus_master #(
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        INT_ADDR_WIDTH = 32,
    parameter int                        EXT_ADDR_WIDTH = 16,
    parameter logic [INT_ADDR_WIDTH-1:0] MAX_MEM_ADDR   = 32'h3fff,
    parameter int                        TIMEOUT_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [1:0]                i_req_size,
    input  logic                      i_req_unsigned,
    input  logic [INT_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0]     i_req_wdata,
    output logic                      o_rsp_valid,
    output logic                      o_rsp_err,
    output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
    input  logic                      i_bus_rdy,
    input  logic [DATA_WIDTH-1:0]     i_data_bus_recv,
    output logic                      o_bus_en,
    output logic                      o_bus_we,
    output logic [1:0]                o_bus_size,
    output logic [EXT_ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0]     o_data_bus_drv,
    output logic                      o_data_bus_o_en,
    output logic                      o_data_bus_i_en,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The counter is cleared in SETUP. It then holds the number of ACCESS
    // edges already taken. The edge that would make it TIMEOUT_CYCLES is the
    // last ACCESS edge.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [7:0]                r_cnt;

    // Request fields needed after acceptance.
    logic                      r_we;
    logic                      r_unsigned;
    logic [1:0]                r_addr_lo;

    // Registered outputs.
    logic                      r_rsp_valid;
    logic                      r_rsp_err;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_bus_en;
    logic                      r_bus_we;
    logic [1:0]                r_bus_size;
    logic [EXT_ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0]     r_drv;
    logic                      r_o_en;
    logic                      r_i_en;

    // Next values of the registered outputs.
    logic                      w_rsp_valid_nxt;
    logic                      w_rsp_err_nxt;
    logic [DATA_WIDTH-1:0]     w_rsp_rdata_nxt;
    logic                      w_bus_en_nxt;
    logic                      w_bus_we_nxt;
    logic [1:0]                w_bus_size_nxt;
    logic [EXT_ADDR_WIDTH-1:0] w_bus_addr_nxt;
    logic [DATA_WIDTH-1:0]     w_drv_nxt;
    logic                      w_o_en_nxt;
    logic                      w_i_en_nxt;

    logic                      w_req_bad;
    logic                      w_timeout;
    logic [DATA_WIDTH-1:0]     w_wdata_rep;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [DATA_WIDTH-1:0]     w_load_data;

    // Request legality: illegal size, misalignment or out-of-range address.
    always_comb begin
        w_req_bad = 1'b0;
        if (i_req_size == 2'd3)                                w_req_bad = 1'b1;
        if (i_req_size == 2'd1 && i_req_addr[0])               w_req_bad = 1'b1;
        if (i_req_size == 2'd2 && (i_req_addr[1:0] != 2'b00))  w_req_bad = 1'b1;
        if (i_req_addr > MAX_MEM_ADDR)                         w_req_bad = 1'b1;
    end

    // Store data is replicated across all lanes. The slave then finds its
    // bytes in the lane selected by the low address bits.
    always_comb begin
        case (i_req_size)
            2'd0:    w_wdata_rep = {(DATA_WIDTH/8){i_req_wdata[7:0]}};
            2'd1:    w_wdata_rep = {(DATA_WIDTH/16){i_req_wdata[15:0]}};
            default: w_wdata_rep = i_req_wdata;
        endcase
    end

    // Little-endian lane extraction of read data, followed by extension.
    assign w_byte = 8'(i_data_bus_recv >> {r_addr_lo, 3'b000});
    assign w_half = 16'(i_data_bus_recv >> {r_addr_lo[1], 4'b0000});

    always_comb begin
        case (r_bus_size)
            2'd0:    w_load_data = {{(DATA_WIDTH-8){w_byte[7] & ~r_unsigned}}, w_byte};
            2'd1:    w_load_data = {{(DATA_WIDTH-16){w_half[15] & ~r_unsigned}}, w_half};
            default: w_load_data = i_data_bus_recv;
        endcase
    end

    assign w_timeout = (r_cnt == TO_LAST);

    // State register, request latch, timeout counter and output flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_size  <= 2'b00;
            r_bus_addr  <= '0;
            r_drv       <= '0;
            r_o_en      <= 1'b0;
            r_i_en      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_bus_en    <= w_bus_en_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_size  <= w_bus_size_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_drv       <= w_drv_nxt;
            r_o_en      <= w_o_en_nxt;
            r_i_en      <= w_i_en_nxt;
            if (r_state == ST_IDLE && i_req_valid) begin
                r_we       <= i_req_we;
                r_unsigned <= i_req_unsigned;
                r_addr_lo  <= i_req_addr[1:0];
            end
            if (r_state == ST_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_req_valid) w_state_nxt = w_req_bad ? ST_RESP : ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (i_bus_rdy || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. It computes the flop values for the cycle that follows
    // the edge. Address, size and drive data hold unless a new legal request
    // loads them. All strobes and enables default to low.
    always_comb begin
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_bus_en_nxt    = 1'b0;
        w_bus_we_nxt    = 1'b0;
        w_bus_size_nxt  = r_bus_size;
        w_bus_addr_nxt  = r_bus_addr;
        w_drv_nxt       = r_drv;
        w_o_en_nxt      = 1'b0;
        w_i_en_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (w_req_bad) begin
                        // Rejected without touching the bus.
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_bus_addr_nxt = i_req_addr[EXT_ADDR_WIDTH-1:0];
                        w_bus_size_nxt = i_req_size;
                        w_bus_we_nxt   = i_req_we;
                        w_o_en_nxt     = i_req_we;
                        w_drv_nxt      = i_req_we ? w_wdata_rep : '0;
                    end
                end
            end
            ST_SETUP: begin
                w_bus_en_nxt = 1'b1;
                w_bus_we_nxt = r_we;
                w_o_en_nxt   = r_we;
                w_i_en_nxt   = ~r_we;
            end
            ST_ACCESS: begin
                // A completion on the timeout edge still counts as success.
                if (i_bus_rdy) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_we ? '0 : w_load_data;
                end else if (w_timeout) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_bus_en_nxt = 1'b1;
                    w_bus_we_nxt = r_we;
                    w_o_en_nxt   = r_we;
                    w_i_en_nxt   = ~r_we;
                end
            end
            default: ; // RESP: bus turnaround, every enable stays low
        endcase
    end

    assign o_req_ready     = (r_state == ST_IDLE);
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_err       = r_rsp_err;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_bus_en        = r_bus_en;
    assign o_bus_we        = r_bus_we;
    assign o_bus_size      = r_bus_size;
    assign o_bus_addr      = r_bus_addr;
    assign o_data_bus_drv  = r_drv;
    assign o_data_bus_o_en = r_o_en;
    assign o_data_bus_i_en = r_i_en;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_ext_bus_master.sv
module tb_ext_bus_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_rdy;
    logic [31:0] data_bus_recv;
    logic        bus_en;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [15:0] bus_addr;
    logic [31:0] data_bus_drv;
    logic        data_bus_o_en;
    logic        data_bus_i_en;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    logic [31:0] exp_q[$];

    // Observations collected by run_txn.
    int          m_rsp_cyc, m_en_cnt, m_oen_cnt, m_ien_cnt, m_acc_cyc;
    logic        m_err, m_overlap, m_unstable, m_idle_after, m_resp_quiet;
    logic [31:0] m_rdata;
    logic [15:0] s_addr;
    logic [1:0]  s_size, s_state;
    logic        s_we, s_en, s_oen, s_ien;
    logic [31:0] s_drv;

    ext_bus_master dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_we        (req_we),
        .i_req_size      (req_size),
        .i_req_unsigned  (req_unsigned),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_err       (rsp_err),
        .o_rsp_rdata     (rsp_rdata),
        .i_bus_rdy       (bus_rdy),
        .i_data_bus_recv (data_bus_recv),
        .o_bus_en        (bus_en),
        .o_bus_we        (bus_we),
        .o_bus_size      (bus_size),
        .o_bus_addr      (bus_addr),
        .o_data_bus_drv  (data_bus_drv),
        .o_data_bus_o_en (data_bus_o_en),
        .o_data_bus_i_en (data_bus_i_en),
        .o_dbg_state     (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Driver: issues one request from IDLE and follows it to its response.
    // Cycle 1 is the cycle after the accepting edge. bus_rdy is driven high
    // during cycle rdy_cyc (0 = never). On return the bench is one cycle
    // past the response cycle.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int rdy_cyc, input logic [31:0] recv);
        int c;
        req_we        = we;
        req_size      = size;
        req_unsigned  = uns;
        req_addr      = addr;
        req_wdata     = wdata;
        data_bus_recv = recv;
        bus_rdy       = 1'b0;
        req_valid     = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        m_acc_cyc    = cyc_cnt;
        m_rsp_cyc    = 0;
        m_en_cnt     = 0;
        m_oen_cnt    = 0;
        m_ien_cnt    = 0;
        m_err        = 1'bx;
        m_rdata      = 'x;
        m_overlap    = 1'b0;
        m_unstable   = 1'b0;
        m_resp_quiet = 1'b0;
        s_addr  = bus_addr;
        s_size  = bus_size;
        s_we    = bus_we;
        s_en    = bus_en;
        s_oen   = data_bus_o_en;
        s_ien   = data_bus_i_en;
        s_drv   = data_bus_drv;
        s_state = dbg_state;
        c = 1;
        while (c <= 300) begin
            if (data_bus_o_en && data_bus_i_en) m_overlap = 1'b1;
            if (bus_en) begin
                m_en_cnt++;
                if (bus_addr !== s_addr || bus_size !== s_size || bus_we !== s_we || data_bus_drv !== s_drv)
                    m_unstable = 1'b1;
            end
            if (data_bus_o_en) m_oen_cnt++;
            if (data_bus_i_en) m_ien_cnt++;
            if (rsp_valid) begin
                m_rsp_cyc    = c;
                m_err        = rsp_err;
                m_rdata      = rsp_rdata;
                m_resp_quiet = !(bus_en || bus_we || data_bus_o_en || data_bus_i_en);
                break;
            end
            bus_rdy = (c == rdy_cyc);
            @(posedge clk); #1;
            c++;
        end
        bus_rdy = 1'b0;
        @(posedge clk); #1;
        m_idle_after = req_ready && !rsp_valid && !data_bus_o_en && !data_bus_i_en;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; bus_rdy = 1'b0; data_bus_recv = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (bus_en !== 1'b0 || bus_we !== 1'b0 || bus_size !== 2'd0) begin bad++; $display("FAIL rst_bus_ctl: got en=%b we=%b sz=%0d want 0", bus_en, bus_we, bus_size); end
        total++; if (bus_addr !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h want 0000", bus_addr); end
        total++; if (data_bus_drv !== 32'h0) begin bad++; $display("FAIL rst_drv: got %h want 0", data_bus_drv); end
        total++; if (data_bus_o_en !== 1'b0 || data_bus_i_en !== 1'b0) begin bad++; $display("FAIL rst_pad_en: got o=%b i=%b want 0", data_bus_o_en, data_bus_i_en); end
        reset = 1'b0;

        // Abort a load from ACCESS.
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus_en !== 1'b1 || dbg_state !== 2'd2) begin bad++; $display("FAIL abort_in_access: got en=%b st=%0d want en=1 st=2", bus_en, dbg_state); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (dbg_state !== 2'd0 || req_ready !== 1'b1) begin bad++; $display("FAIL abort_state: got st=%0d rdy=%b want 0/1", dbg_state, req_ready); end
        total++; if (bus_en !== 1'b0 || data_bus_i_en !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_outputs: got en=%b ien=%b v=%b want 0", bus_en, data_bus_i_en, rsp_valid); end
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_rsp: got rsp_valid seen=%b want 0", seen); end
    endtask

    task automatic test_word_store();
        run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4, 32'h0);
        total++; if (s_addr !== 16'h0100 || s_size !== 2'd2 || s_we !== 1'b1) begin bad++; $display("FAIL ws_setup_bus: got a=%h sz=%0d we=%b want 0100/2/1", s_addr, s_size, s_we); end
        total++; if (s_en !== 1'b0 || s_oen !== 1'b1 || s_state !== 2'd1) begin bad++; $display("FAIL ws_setup_phase: got en=%b oen=%b st=%0d want 0/1/1", s_en, s_oen, s_state); end
        total++; if (s_drv !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_drv: got %h want deadbeef", s_drv); end
        total++; if (m_en_cnt != 3) begin bad++; $display("FAIL ws_en_cycles: got %0d want 3", m_en_cnt); end
        total++; if (m_oen_cnt != 4 || m_ien_cnt != 0) begin bad++; $display("FAIL ws_oen_cycles: got o=%0d i=%0d want 4/0", m_oen_cnt, m_ien_cnt); end
        total++; if (m_rsp_cyc != 5) begin bad++; $display("FAIL ws_rsp_cycle: got %0d want 5", m_rsp_cyc); end
        total++; if (m_err !== 1'b0 || m_rdata !== 32'h0) begin bad++; $display("FAIL ws_rsp: got e=%b d=%h want 0/0", m_err, m_rdata); end
        total++; if (m_unstable !== 1'b0 || m_overlap !== 1'b0) begin bad++; $display("FAIL ws_stable: got unstable=%b overlap=%b want 0/0", m_unstable, m_overlap); end
        total++; if (m_resp_quiet !== 1'b1 || m_idle_after !== 1'b1) begin bad++; $display("FAIL ws_turnaround: got quiet=%b idle=%b want 1/1", m_resp_quiet, m_idle_after); end
        total++; if (bus_addr !== 16'h0100 || data_bus_drv !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_hold: got a=%h d=%h want 0100/deadbeef", bus_addr, data_bus_drv); end
    endtask

    task automatic test_loads();
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 2, 32'h8011_2233);
        total++; if (m_rsp_cyc != 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", m_rsp_cyc); end
        total++; if (m_err !== 1'b0 || m_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_signed: got e=%b d=%h want 0/ffffff80", m_err, m_rdata); end
        total++; if (m_ien_cnt != 1 || m_oen_cnt != 0 || s_oen !== 1'b0) begin bad++; $display("FAIL lb_pad_en: got i=%0d o=%0d so=%b want 1/0/0", m_ien_cnt, m_oen_cnt, s_oen); end
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 2, 32'h8011_2233);
        total++; if (m_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_unsigned: got %h want 00000080", m_rdata); end
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 2, 32'h8011_2233);
        total++; if (m_rdata !== 32'h0000_0022) begin bad++; $display("FAIL lb_lane1: got %h want 00000022", m_rdata); end
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 2, 32'h8011_2233);
        total++; if (m_rdata !== 32'hFFFF_8011 || s_size !== 2'd1) begin bad++; $display("FAIL lh_signed: got d=%h sz=%0d want ffff8011/1", m_rdata, s_size); end
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0, 2, 32'h8011_A233);
        total++; if (m_rdata !== 32'h0000_A233) begin bad++; $display("FAIL lhu_lane0: got %h want 0000a233", m_rdata); end
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_3FFF, 32'h0, 2, 32'h5A00_0000);
        total++; if (m_err !== 1'b0 || m_rdata !== 32'h0000_005A) begin bad++; $display("FAIL lb_max_addr: got e=%b d=%h want 0/0000005a", m_err, m_rdata); end
    endtask

    task automatic test_narrow_stores();
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 2, 32'h0);
        total++; if (s_drv !== 32'hABCD_ABCD || s_size !== 2'd1 || s_addr !== 16'h0002) begin bad++; $display("FAIL hs_drv: got d=%h sz=%0d a=%h want abcdabcd/1/0002", s_drv, s_size, s_addr); end
        total++; if (m_err !== 1'b0 || m_rdata !== 32'h0 || m_rsp_cyc != 3) begin bad++; $display("FAIL hs_rsp: got e=%b d=%h cyc=%0d want 0/0/3", m_err, m_rdata, m_rsp_cyc); end
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h7788_995A, 2, 32'h0);
        total++; if (s_drv !== 32'h5A5A_5A5A || s_size !== 2'd0) begin bad++; $display("FAIL bs_drv: got d=%h sz=%0d want 5a5a5a5a/0", s_drv, s_size); end
    endtask

    task automatic test_req_errors();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 2, 32'h1111_1111);
        total++; if (m_rsp_cyc != 1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin bad++; $display("FAIL err_word_align: got cyc=%0d e=%b d=%h want 1/1/0", m_rsp_cyc, m_err, m_rdata); end
        total++; if (m_en_cnt != 0 || m_oen_cnt != 0 || m_ien_cnt != 0) begin bad++; $display("FAIL err_no_bus: got en=%0d o=%0d i=%0d want 0", m_en_cnt, m_oen_cnt, m_ien_cnt); end
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_4000, 32'h0, 2, 32'h0);
        total++; if (m_rsp_cyc != 1 || m_err !== 1'b1) begin bad++; $display("FAIL err_range: got cyc=%0d e=%b want 1/1", m_rsp_cyc, m_err); end
        run_txn(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 2, 32'h0);
        total++; if (m_rsp_cyc != 1 || m_err !== 1'b1 || m_en_cnt != 0) begin bad++; $display("FAIL err_size3: got cyc=%0d e=%b en=%0d want 1/1/0", m_rsp_cyc, m_err, m_en_cnt); end
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 2, 32'h0);
        total++; if (m_rsp_cyc != 1 || m_err !== 1'b1 || m_oen_cnt != 0) begin bad++; $display("FAIL err_half_align: got cyc=%0d e=%b o=%0d want 1/1/0", m_rsp_cyc, m_err, m_oen_cnt); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h1234_5678);
        total++; if (m_rsp_cyc != 66 || m_err !== 1'b1 || m_rdata !== 32'h0) begin bad++; $display("FAIL to_expire: got cyc=%0d e=%b d=%h want 66/1/0", m_rsp_cyc, m_err, m_rdata); end
        total++; if (m_en_cnt != 64 || m_ien_cnt != 64) begin bad++; $display("FAIL to_access_cycles: got en=%0d i=%0d want 64/64", m_en_cnt, m_ien_cnt); end
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, 65, 32'hCAFE_F00D);
        total++; if (m_rsp_cyc != 66 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL to_last_edge_rdy: got cyc=%0d e=%b d=%h want 66/0/cafef00d", m_rsp_cyc, m_err, m_rdata); end
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0208, 32'h0, 64, 32'h0BAD_CAFE);
        total++; if (m_rsp_cyc != 65 || m_err !== 1'b0 || m_rdata !== 32'h0BAD_CAFE) begin bad++; $display("FAIL to_before_last: got cyc=%0d e=%b d=%h want 65/0/0badcafe", m_rsp_cyc, m_err, m_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int prev_acc;
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFA5);
        exp_q.push_back(32'h0000_00C3);
        exp_q.push_back(32'h0000_7E01);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0, 2, 32'h0000_00A5);
        prev_acc = m_acc_cyc;
        exp = exp_q.pop_front();
        total++; if (m_rdata !== exp) begin bad++; $display("FAIL b2b_data0: got %h want %h", m_rdata, exp); end
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0, 2, 32'h00C3_0000);
        exp = exp_q.pop_front();
        total++; if (m_rdata !== exp) begin bad++; $display("FAIL b2b_data1: got %h want %h", m_rdata, exp); end
        total++; if (m_acc_cyc - prev_acc != 4) begin bad++; $display("FAIL b2b_spacing1: got %0d want 4", m_acc_cyc - prev_acc); end
        prev_acc = m_acc_cyc;
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0016, 32'h0, 2, 32'h7E01_FFFF);
        exp = exp_q.pop_front();
        total++; if (m_rdata !== exp) begin bad++; $display("FAIL b2b_data2: got %h want %h", m_rdata, exp); end
        total++; if (m_acc_cyc - prev_acc != 4) begin bad++; $display("FAIL b2b_spacing2: got %0d want 4", m_acc_cyc - prev_acc); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_narrow_stores();
        test_req_errors();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
